aes_mixcol_pipe: RTL and testbench
==================================

// Module: aes_mixcol_pipe
// PURPOSE
//  Parametrised, stallable MixColumns/InvMixColumns round stage for the AES datapath.
//  Processes NCOLS 32-bit state columns per beat and passes the round key and Rcon alongside.
//  Full throughput with valid/ready backpressure; per-beat mode (encrypt/decrypt) and bypass (final round).
//  Sits between ShiftRows/SubBytes and AddRoundKey in the round pipeline.
// PARAMETERS
//  NCOLS        4  columns per beat, 1..4; state/key width = 32*NCOLS
//  PIPE_STAGES  2  register stages, 1..4; latency in cycles with no backpressure
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        input beat present
//  in_ready   out  1        stage accepts a beat this cycle
//  in_state   in   32*NCOLS state; byte r of column c at [32*c+8*r +: 8]
//  in_key     in   32*NCOLS round key, same byte layout, carried unmodified
//  in_rcon    in   8        current Rcon
//  in_inv     in   1        1 = InvMixColumns, 0 = MixColumns
//  in_bypass  in   1        1 = state passes unchanged (final round)
//  out_valid  out  1        output beat present
//  out_ready  in   1        downstream accepts
//  out_state  out  32*NCOLS mixed (or bypassed) state
//  out_key    out  32*NCOLS key delayed to match out_state
//  out_rcon   out  8        next Rcon: fwd xtime(rcon); inv xtime^-1(rcon)
// BEHAVIOUR
//  - Reset: every stage valid=0, all data regs 0; out_valid=0, out_state/out_key/out_rcon=0; in_ready=1.
//  - Transfer on valid&ready at each end. in_ready = !v[0] | adv[0]; adv[k] = !v[k+1] | adv[k+1];
//    adv[last] = out_ready. Combinational ready path, no bubbles, 1 beat/cycle sustained.
//  - out_valid held and out_* stable while out_valid & !out_ready.
//  - Latency exactly PIPE_STAGES cycles from accept to out_valid if never stalled.
//  - in_inv/in_bypass/in_key/in_rcon captured with the beat, travel with it; mode changes never affect in-flight beats.
//  - GF(2^8), poly 0x11b: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
//    Fwd column: o_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
//    Inv column: o_r = 14*a_r ^ 11*a_(r+1) ^ 13*a_(r+2) ^ 9*a_(r+3) (x2, x4, x8 via chained xtime).
//  - Rcon fwd: xtime(rcon) (0x80 -> 0x1b). Inv: rcon[0] ? ((rcon^8'h1b)>>1)|8'h80 : rcon>>1 (0x1b -> 0x80, 0x01 -> 0x8d).
//    Rcon update also applies when in_bypass=1.
//  - PIPE_STAGES=1: all logic ahead of the single register. >=2: stage 1 registers
//    byte multiples (x1,x2,x3 fwd; x9,x11,x13,x14 inv), stage 2 registers column XOR sums, later stages pure delay.
//  - Reset asserted mid-operation: all in-flight beats discarded, out_valid drops asynchronously.
//  - Simultaneous accept and emit with full pipe is legal and loses nothing.
// CONFIGURATION
//  - Macro AES_MIXCOL_ADDKEY_EN defined: out_state = mix(state) ^ key (bypass: state ^ key);
//    AddRoundKey folded into the final combine stage; out_key still emitted; latency unchanged.
//  - Undefined: out_state = mix(state) or state; key carried only.
// STRUCTURE
//  - aes_pkg: AES_POLY = 8'h1b; functions xtime, inv_xtime, gmul9/11/13/14; column byte-slice helper.
//  - Sub-module aes_mix_column: one 32-bit column, fwd/inv selectable, split into product/sum halves
//    so the parent registers between them; parent generates NCOLS instances plus valid/stall chain.
// TESTING
//  - Fwd, NCOLS=1: col 32'h455313db, inv=0 -> 32'hbca14d8e; col 32'h5c220af2 -> 32'h9d58dc9f.
//  - Inv: col 32'hbca14d8e, inv=1 -> 32'h455313db; round-trip 256 random NCOLS=4 states fwd then inv -> identity.
//  - Rcon: 0x01..0x80 fwd -> 0x02..0x1b; inv 0x1b -> 0x80, 0x01 -> 0x8d; bypass=1 state 32'hdeadbeef passes unchanged.
//  - Backpressure: 20 back-to-back beats, out_ready toggled 1/0 pseudo-random -> all 20 out in order,
//    no duplicates, out_* stable during stall, in_ready low only when pipe full and stalled.
//  - Reset mid-stream with 2 beats in flight -> out_valid=0 and outputs 0 immediately; next beat after release
//    emerges after exactly PIPE_STAGES cycles.
//  - AES_MIXCOL_ADDKEY_EN: state col 32'h455313db, key 32'hffffffff -> 32'h435eb271; sweep PIPE_STAGES 1..4, NCOLS 1/4.

Source files
------------

// File: rtl/aes_mixcol_pipe_pkg.sv
// Shared GF(2^8) arithmetic and types for the AES MixColumns round stage.
package aes_mixcol_pipe_pkg;

  // Reduction constant of the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] AES_POLY = 8'h1b;

  // Per-beat transform selected at the input of the stage
  typedef enum logic [1:0] {
    MODE_FWD    = 2'd0,
    MODE_INV    = 2'd1,
    MODE_BYPASS = 2'd2
  } mix_mode_e;

  // Multiply by x (i.e. by 2) in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Divide by x in GF(2^8); exact inverse of xtime
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ AES_POLY) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte r (row) of a 32-bit column
  function automatic logic [7:0] col_byte(input logic [31:0] col, input int r);
    return col[8*r +: 8];
  endfunction

  // Rcon for the following round: forward multiplies by x, inverse divides
  function automatic logic [7:0] next_rcon(input logic [7:0] rcon, input logic inv);
    return inv ? inv_xtime(rcon) : xtime(rcon);
  endfunction

endpackage

// File: rtl/aes_mixcol_pipe_if.sv
// Handshake and data bus of the MixColumns stage: upstream beat in, mixed beat out.
interface aes_mixcol_pipe_if #(
  parameter int NCOLS = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [32*NCOLS-1:0]  in_state;
  logic [32*NCOLS-1:0]  in_key;
  logic [7:0]           in_rcon;
  logic                 in_inv;
  logic                 in_bypass;
  logic                 out_valid;
  logic                 out_ready;
  logic [32*NCOLS-1:0]  out_state;
  logic [32*NCOLS-1:0]  out_key;
  logic [7:0]           out_rcon;

  // Stage side
  modport slave (
    input  in_valid, in_state, in_key, in_rcon, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_state, out_key, out_rcon
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_state, in_key, in_rcon, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, out_key, out_rcon
  );
endinterface

// File: rtl/aes_mixcol_pipe_mix_column.sv
// One AES column transform split into a product half (per-byte field multiples)
// and a sum half (XOR combine), so the parent can register between them.
// Product layout: byte r owns prod[32*r +: 32]; slot j (prod[32*r+8*j +: 8]) holds
// the multiple used when byte r sits at offset j from the output row.
module aes_mixcol_pipe_mix_column
  import aes_mixcol_pipe_pkg::*;
(
  input  logic [31:0]  col_i,
  input  mix_mode_e    mode_i,
  output logic [127:0] prod_o,
  input  logic [127:0] prod_i,
  output logic [31:0]  sum_o
);

  // Multiples of one byte for offsets 0..3; bypass keeps only the identity term
  function automatic logic [31:0] byte_products(input logic [7:0] a, input mix_mode_e mode);
    logic [7:0] x2;
    x2 = xtime(a);
    case (mode)
      MODE_FWD: return {a, a, x2 ^ a, x2};
      MODE_INV: return {gmul9(a), gmul13(a), gmul11(a), gmul14(a)};
      default:  return {24'h000000, a};
    endcase
  endfunction

  // o_r = XOR over j of slot j of byte (r+j) mod 4
  function automatic logic [31:0] col_sum(input logic [127:0] p);
    logic [31:0] s;
    s = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        s[8*r +: 8] = s[8*r +: 8] ^ p[32*((r + j) % 4) + 8*j +: 8];
      end
    end
    return s;
  endfunction

  // Product half: field multiples of every byte of the column
  always_comb begin
    prod_o = '0;
    for (int r = 0; r < 4; r++) begin
      prod_o[32*r +: 32] = byte_products(col_byte(col_i, r), mode_i);
    end
  end

  assign sum_o = col_sum(prod_i);

endmodule

// File: rtl/aes_mixcol_pipe.sv
// Stallable MixColumns / InvMixColumns round stage, NCOLS columns per beat.
// Key and next Rcon travel with each beat; valid/ready backpressure with a
// combinational ready chain so the pipe sustains one beat per cycle.
// Optional macro AES_MIXCOL_ADDKEY_EN folds AddRoundKey into the combine stage.
module aes_mixcol_pipe
  import aes_mixcol_pipe_pkg::*;
#(
  parameter int NCOLS       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  aes_mixcol_pipe_if.slave bus
);

  localparam int W  = 32 * NCOLS;
  localparam int PW = 128 * NCOLS;
  localparam int S  = PIPE_STAGES;

  logic [S-1:0]  v_q;
  logic [S-1:0]  ld;
  logic [W-1:0]  key_q  [S];
  logic [7:0]    rcon_q [S];

  mix_mode_e     mode_in;
  logic [PW-1:0] prod_comb;
  logic [PW-1:0] prod_src;
  logic [W-1:0]  mix_comb;
  logic [W-1:0]  fin_comb;

  assign mode_in = bus.in_bypass ? MODE_BYPASS : (bus.in_inv ? MODE_INV : MODE_FWD);

  for (genvar c = 0; c < NCOLS; c++) begin : g_col
    aes_mixcol_pipe_mix_column u_col (
      .col_i  (bus.in_state[32*c +: 32]),
      .mode_i (mode_in),
      .prod_o (prod_comb[128*c +: 128]),
      .prod_i (prod_src[128*c +: 128]),
      .sum_o  (mix_comb[32*c +: 32])
    );
  end

  // Stage k may load when it is empty or its content moves on this cycle
  always_comb begin
    ld        = '0;
    ld[S-1]   = !v_q[S-1] | bus.out_ready;
    for (int k = S - 2; k >= 0; k--) begin
      ld[k] = !v_q[k] | ld[k+1];
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[S-1];
  assign bus.out_key   = key_q[S-1];
  assign bus.out_rcon  = rcon_q[S-1];

  // Valid chain with the key and next Rcon riding alongside each beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < S; k++) begin
        key_q[k]  <= '0;
        rcon_q[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          key_q[0]  <= bus.in_key;
          rcon_q[0] <= next_rcon(bus.in_rcon, bus.in_inv);
        end
      end
      for (int k = 1; k < S; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            key_q[k]  <= key_q[k-1];
            rcon_q[k] <= rcon_q[k-1];
          end
        end
      end
    end
  end

  if (S == 1) begin : g_one
    logic [W-1:0] st_q;

    assign prod_src = prod_comb;
`ifdef AES_MIXCOL_ADDKEY_EN
    assign fin_comb = mix_comb ^ bus.in_key;
`else
    assign fin_comb = mix_comb;
`endif

    // Single register: products and sums both ahead of it
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        st_q <= '0;
      end else if (ld[0] && bus.in_valid) begin
        st_q <= fin_comb;
      end
    end

    assign bus.out_state = st_q;
  end else begin : g_multi
    logic [PW-1:0] prod_q;
    logic [W-1:0]  st_q [S-1];   // st_q[i] belongs to register stage i+1

    assign prod_src = prod_q;
`ifdef AES_MIXCOL_ADDKEY_EN
    assign fin_comb = mix_comb ^ key_q[0];
`else
    assign fin_comb = mix_comb;
`endif

    // Stage 0 holds byte products, stage 1 the column sums, later stages delay
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        prod_q <= '0;
        for (int k = 0; k < S - 1; k++) begin
          st_q[k] <= '0;
        end
      end else begin
        if (ld[0] && bus.in_valid) begin
          prod_q <= prod_comb;
        end
        if (ld[1] && v_q[0]) begin
          st_q[0] <= fin_comb;
        end
        for (int k = 2; k < S; k++) begin
          if (ld[k] && v_q[k-1]) begin
            st_q[k-1] <= st_q[k-2];
          end
        end
      end
    end

    assign bus.out_state = st_q[S-2];
  end

endmodule

// File: tb/tb_aes_mixcol_pipe.sv
// Randomized scoreboard bench for aes_mixcol_pipe with a field-arithmetic model.
module tb_aes_mixcol_pipe;
  parameter int NCOLS       = 4;
  parameter int PIPE_STAGES = 2;
  localparam int W = 32 * NCOLS;

`ifdef AES_MIXCOL_ADDKEY_EN
  localparam bit ADDKEY = 1'b1;
`else
  localparam bit ADDKEY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  aes_mixcol_pipe_if #(.NCOLS(NCOLS)) mc_if ();

  aes_mixcol_pipe #(.NCOLS(NCOLS), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (mc_if)
  );

  typedef struct {
    logic [W-1:0] state;
    logic [W-1:0] key;
    logic [7:0]   rcon;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] orig[$];
  bit           collect = 1'b0;
  int           emitted = 0;
  int           rdy_mode = 1;   // 0 hold off, 1 always ready, 2 random

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---- behavioural model --------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a;
    logic [8:0] t;
    p = 8'h00;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int j);
    case (j)
      0:       return inv ? 8'd14 : 8'd2;
      1:       return inv ? 8'd11 : 8'd3;
      2:       return inv ? 8'd13 : 8'd1;
      default: return inv ? 8'd9  : 8'd1;
    endcase
  endfunction

  function automatic logic [31:0] col_model(input logic [31:0] col, input logic inv);
    logic [31:0] res;
    logic [7:0]  o;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int j = 0; j < 4; j++) o = o ^ gmul(coef(inv, j), col[8*((r + j) % 4) +: 8]);
      res[8*r +: 8] = o;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] state_model(input logic [W-1:0] st, input logic [W-1:0] ky,
                                               input logic inv, input logic byp);
    logic [W-1:0] res;
    for (int c = 0; c < NCOLS; c++)
      res[32*c +: 32] = byp ? st[32*c +: 32] : col_model(st[32*c +: 32], inv);
    if (ADDKEY) res = res ^ ky;
    return res;
  endfunction

  function automatic logic [7:0] rcon_model(input logic [7:0] r, input logic inv);
    if (!inv) return gmul(r, 8'h02);
    for (int x = 0; x < 256; x++)
      if (gmul(8'(x), 8'h02) == r) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int c = 0; c < NCOLS; c++) r[32*c +: 32] = $urandom;
    return r;
  endfunction

  // ---- out_ready driver ---------------------------------------------------
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       mc_if.out_ready = 1'b0;
      1:       mc_if.out_ready = 1'b1;
      default: mc_if.out_ready = 1'($urandom % 2);
    endcase
  end

  // ---- compare process: sampled at the falling edge ------------------------
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_state, prev_key;
  logic [7:0]   prev_rcon;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 128'(mc_if.in_ready),
            128'(!(sb.size() == PIPE_STAGES && !mc_if.out_ready)));
      if (prev_stall) begin
        check("stall_valid", 128'(mc_if.out_valid), 128'(1'b1));
        check("stall_state", 128'(mc_if.out_state), 128'(prev_state));
        check("stall_key",   128'(mc_if.out_key),   128'(prev_key));
        check("stall_rcon",  128'(mc_if.out_rcon),  128'(prev_rcon));
      end
      if (mc_if.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual=out_valid required=no_beat_in_flight");
        end else begin
          check("out_state", 128'(mc_if.out_state), 128'(sb[0].state));
          check("out_key",   128'(mc_if.out_key),   128'(sb[0].key));
          check("out_rcon",  128'(mc_if.out_rcon),  128'(sb[0].rcon));
          if (mc_if.out_ready) begin
            void'(sb.pop_front());
            emitted++;
            if (collect) got_q.push_back(mc_if.out_state);
          end
        end
      end
      prev_stall = mc_if.out_valid && !mc_if.out_ready;
      prev_state = mc_if.out_state;
      prev_key   = mc_if.out_key;
      prev_rcon  = mc_if.out_rcon;
      if (mc_if.in_valid && mc_if.in_ready) begin
        exp_t e;
        e.state = state_model(mc_if.in_state, mc_if.in_key, mc_if.in_inv, mc_if.in_bypass);
        e.key   = mc_if.in_key;
        e.rcon  = rcon_model(mc_if.in_rcon, mc_if.in_inv);
        sb.push_back(e);
      end
    end
  end

  // ---- stimulus helpers ---------------------------------------------------
  task automatic send(input logic [W-1:0] st, input logic [W-1:0] ky, input logic [7:0] rc,
                      input logic inv, input logic byp);
    bit acc;
    int n;
    mc_if.in_valid  = 1'b1;
    mc_if.in_state  = st;
    mc_if.in_key    = ky;
    mc_if.in_rcon   = rc;
    mc_if.in_inv    = inv;
    mc_if.in_bypass = byp;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clock);
      acc = mc_if.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    mc_if.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while ((sb.size() != 0 || mc_if.out_valid) && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_done", 128'(n < 1000), 128'(1'b1));
  endtask

  // One beat into an empty pipe; column 0 and Rcon checked against literals
  task automatic directed(input string name, input logic [31:0] col0, input logic [31:0] key0,
                          input logic [7:0] rc, input logic inv, input logic byp,
                          input logic [31:0] exp_col, input logic [7:0] exp_rcon);
    logic [W-1:0] st, ky;
    int lat;
    drain();
    st = rand_w();
    ky = rand_w();
    st[31:0] = col0;
    ky[31:0] = key0;
    send(st, ky, rc, inv, byp);
    lat = 1;
    while (!mc_if.out_valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(PIPE_STAGES));
    check({name, "_col0"},    128'(mc_if.out_state[31:0]), 128'(exp_col));
    check({name, "_key0"},    128'(mc_if.out_key[31:0]),   128'(key0));
    check({name, "_rcon"},    128'(mc_if.out_rcon),        128'(exp_rcon));
  endtask

  // ---- main sequence ------------------------------------------------------
  logic [7:0] rtab [8];

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] fwd_out[$];
    int n_fly;

    rtab[0] = 8'h02; rtab[1] = 8'h04; rtab[2] = 8'h08; rtab[3] = 8'h10;
    rtab[4] = 8'h20; rtab[5] = 8'h40; rtab[6] = 8'h80; rtab[7] = 8'h1b;

    mc_if.in_valid  = 1'b0;
    mc_if.in_state  = '0;
    mc_if.in_key    = '0;
    mc_if.in_rcon   = 8'h00;
    mc_if.in_inv    = 1'b0;
    mc_if.in_bypass = 1'b0;
    mc_if.out_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 128'(mc_if.out_valid), 128'(1'b0));
    check("rst_out_state", 128'(mc_if.out_state), 128'(0));
    check("rst_out_key",   128'(mc_if.out_key),   128'(0));
    check("rst_out_rcon",  128'(mc_if.out_rcon),  128'(0));
    check("rst_in_ready",  128'(mc_if.in_ready),  128'(1'b1));
    reset_n = 1'b1;

    // Pin the model with known vectors
    check("model_fwd_a", 128'(col_model(32'h455313db, 1'b0)), 128'(32'hbca14d8e));
    check("model_fwd_b", 128'(col_model(32'h5c220af2, 1'b0)), 128'(32'h9d58dc9f));
    check("model_inv_a", 128'(col_model(32'hbca14d8e, 1'b1)), 128'(32'h455313db));
    check("model_rcon_inv_1b", 128'(rcon_model(8'h1b, 1'b1)), 128'(8'h80));
    check("model_rcon_inv_01", 128'(rcon_model(8'h01, 1'b1)), 128'(8'h8d));
    for (int r = 0; r < 8; r++)
      check("model_rcon_fwd", 128'(rcon_model(8'(1 << r), 1'b0)), 128'(rtab[r]));
    for (int i = 0; i < 256; i++) begin
      x = rand_w();
      check("model_roundtrip",
            128'(state_model(state_model(x, '0, 1'b0, 1'b0), '0, 1'b1, 1'b0)), 128'(x));
    end

    // Directed DUT vectors
    directed("fwd_a", 32'h455313db, 32'hffffffff, 8'h01, 1'b0, 1'b0,
             ADDKEY ? 32'h435eb271 : 32'hbca14d8e, 8'h02);
    directed("fwd_b", 32'h5c220af2, 32'h00000000, 8'h80, 1'b0, 1'b0, 32'h9d58dc9f, 8'h1b);
    directed("inv_a", 32'hbca14d8e, 32'h00000000, 8'h1b, 1'b1, 1'b0, 32'h455313db, 8'h80);
    directed("bypass", 32'hdeadbeef, 32'h00000000, 8'h01, 1'b1, 1'b1, 32'hdeadbeef, 8'h8d);
    for (int r = 0; r < 8; r++)
      directed("rcon_fwd", 32'h455313db, 32'h00000000, 8'(1 << r), 1'b0, 1'b0,
               32'hbca14d8e, rtab[r]);

    // Random stream with idle gaps and random backpressure
    drain();
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(rand_w(), rand_w(), 8'($urandom), 1'($urandom), 1'($urandom % 4 == 0));
      repeat ($urandom % 3) begin
        @(posedge clock);
        #1;
      end
    end

    // 20 back-to-back beats under pseudo-random out_ready
    drain();
    emitted = 0;
    rdy_mode = 2;
    for (int i = 0; i < 20; i++)
      send(rand_w(), rand_w(), 8'($urandom), 1'($urandom), 1'b0);
    drain();
    check("burst_emitted", 128'(emitted), 128'(20));

    // DUT round trip: 256 forward beats, then their outputs back through inverse
    drain();
    orig.delete();
    got_q.delete();
    collect = 1'b1;
    rdy_mode = 2;
    for (int i = 0; i < 256; i++) begin
      x = rand_w();
      orig.push_back(x);
      send(x, '0, 8'h01, 1'b0, 1'b0);
    end
    drain();
    check("rt_fwd_count", 128'(got_q.size()), 128'(256));
    fwd_out = got_q;
    got_q.delete();
    rdy_mode = 2;
    for (int i = 0; i < fwd_out.size(); i++) send(fwd_out[i], '0, 8'h01, 1'b1, 1'b0);
    drain();
    collect = 1'b0;
    check("rt_inv_count", 128'(got_q.size()), 128'(256));
    for (int i = 0; i < got_q.size() && i < orig.size(); i++)
      check("rt_identity", 128'(got_q[i]), 128'(orig[i]));

    // Reset with beats in flight
    drain();
    rdy_mode = 0;
    n_fly = (PIPE_STAGES < 2) ? PIPE_STAGES : 2;
    for (int i = 0; i < n_fly; i++) send(rand_w(), rand_w(), 8'h01, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 128'(mc_if.out_valid), 128'(1'b0));
    check("midrst_out_state", 128'(mc_if.out_state), 128'(0));
    check("midrst_out_key",   128'(mc_if.out_key),   128'(0));
    check("midrst_out_rcon",  128'(mc_if.out_rcon),  128'(0));
    check("midrst_in_ready",  128'(mc_if.in_ready),  128'(1'b1));
    rdy_mode = 1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    directed("post_rst", 32'h5c220af2, 32'h00000000, 8'h02, 1'b0, 1'b0, 32'h9d58dc9f, 8'h04);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
